// File: rtl/axis_adapter_cobs_decoder.sv
// -----------------------------------------------------------------------------
// axis_adapter_cobs_decoder
//
// Purpose:
//   Decodes a COBS-encoded byte stream (typically the receive side of a UART)
//   into AXI-Stream frames. Frames are delimited only by 0x00 bytes on the
//   input. Each decoded payload byte is held back by one decoded byte. This
//   lets the byte that closes a frame carry tlast (and tuser for errored
//   frames). A delimiter that arrives in the middle of a COBS block marks the
//   frame as truncated. Such a frame is flagged on tuser, pulses frame_error
//   and bumps a saturating error counter.
//
// Ports:
//   clk            in   single clock for all logic
//   reset          in   asynchronous, active-low reset
//   s_axis_tdata   in   [7:0] COBS-encoded input byte
//   s_axis_tvalid  in   input byte valid
//   s_axis_tready  out  input byte accepted (output slot empty or draining)
//   m_axis_tdata   out  [7:0] decoded payload byte
//   m_axis_tvalid  out  output byte valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  last byte of a decoded frame
//   m_axis_tuser   out  frame-error flag, meaningful only with tlast
//   frame_error    out  one-cycle pulse per errored frame
//   error_count    out  [ERR_CNT_WIDTH-1:0] saturating errored-frame count
// -----------------------------------------------------------------------------
module axis_adapter_cobs_decoder #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     frame_error,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    // CODE: the next byte is a COBS code byte.
    // DATA: cnt literal data bytes of the current block remain.
    typedef enum logic {
        CODE,
        DATA
    } state_t;

    state_t                   state, state_n;
    logic [7:0]               cnt, cnt_n;
    logic                     pending_zero, pending_zero_n;
    logic [7:0]               hold_data, hold_data_n;
    logic                     hold_valid, hold_valid_n;

    logic [7:0]               out_data_n;
    logic                     out_valid_n;
    logic                     out_last_n;
    logic                     out_user_n;
    logic                     frame_error_n;
    logic [ERR_CNT_WIDTH-1:0] error_count_n;

    // Per-byte decode decisions, applied to the hold/output path below.
    logic                     accept;
    logic                     do_produce;
    logic [7:0]               produce_byte;
    logic                     do_end;
    logic                     end_err;

    // The only stall source is a full output slot that is not draining.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_n        = state;
        cnt_n          = cnt;
        pending_zero_n = pending_zero;
        hold_data_n    = hold_data;
        hold_valid_n   = hold_valid;
        do_produce     = 1'b0;
        produce_byte   = 8'h00;
        do_end         = 1'b0;
        end_err        = 1'b0;

        // The slot empties when its beat is taken. It refills only if this
        // cycle moves the hold byte forward.
        out_data_n     = m_axis_tdata;
        out_valid_n    = m_axis_tvalid && !m_axis_tready;
        out_last_n     = m_axis_tlast;
        out_user_n     = m_axis_tuser;
        frame_error_n  = 1'b0;
        error_count_n  = error_count;

        // Step 1: classify the accepted byte.
        if (accept) begin
            unique case (state)
                CODE: begin
                    if (s_axis_tdata == 8'h00) begin
                        do_end  = 1'b1;
                        end_err = 1'b0;
                    end else begin
                        // The previous block's implied zero is real only
                        // because another block follows it in this frame.
                        if (pending_zero) begin
                            do_produce   = 1'b1;
                            produce_byte = 8'h00;
                        end
                        cnt_n          = s_axis_tdata - 8'd1;
                        pending_zero_n = (s_axis_tdata != 8'hFF);
                        state_n        = (s_axis_tdata > 8'd1) ? DATA : CODE;
                    end
                end
                DATA: begin
                    if (s_axis_tdata == 8'h00) begin
                        // Delimiter inside a block: truncated frame.
                        do_end  = 1'b1;
                        end_err = 1'b1;
                    end else begin
                        do_produce   = 1'b1;
                        produce_byte = s_axis_tdata;
                        cnt_n        = cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state_n = CODE;
                        end
                    end
                end
                default: state_n = CODE;
            endcase
        end

        // Step 2: a new decoded byte pushes the held one out as a middle beat.
        if (do_produce) begin
            if (hold_valid) begin
                out_data_n  = hold_data;
                out_valid_n = 1'b1;
                out_last_n  = 1'b0;
                out_user_n  = 1'b0;
            end
            hold_data_n  = produce_byte;
            hold_valid_n = 1'b1;
        end

        // Step 3: the frame ends. The held byte becomes the last beat. Any
        // pending implied zero is dropped, because it is the trailing zero
        // of the last block. An empty frame emits nothing.
        if (do_end) begin
            if (hold_valid) begin
                out_data_n  = hold_data;
                out_valid_n = 1'b1;
                out_last_n  = 1'b1;
                out_user_n  = end_err;
            end
            hold_valid_n   = 1'b0;
            pending_zero_n = 1'b0;
            state_n        = CODE;
            if (end_err) begin
                frame_error_n = 1'b1;
                if (error_count != {ERR_CNT_WIDTH{1'b1}}) begin
                    error_count_n = error_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= CODE;
            cnt           <= 8'h00;
            pending_zero  <= 1'b0;
            hold_data     <= 8'h00;
            hold_valid    <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_error   <= 1'b0;
            error_count   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed above.
            state         <= state_n;
            cnt           <= cnt_n;
            pending_zero  <= pending_zero_n;
            hold_data     <= hold_data_n;
            hold_valid    <= hold_valid_n;
            m_axis_tdata  <= out_data_n;
            m_axis_tvalid <= out_valid_n;
            m_axis_tlast  <= out_last_n;
            m_axis_tuser  <= out_user_n;
            frame_error   <= frame_error_n;
            error_count   <= error_count_n;
        end
    end

endmodule

// File: doc/axis_adapter_cobs_decoder.md
AXIS_ADAPTER_COBS_DECODER -- requirements
Module: axis_adapter_cobs_decoder

Interface
REQ-001 The module SHALL take parameter ERR_CNT_WIDTH, default 16, which sets the width of the saturating frame-error counter.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: the single clock for all logic.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port s_axis_tdata, input, 8: COBS-encoded byte stream (UART rx side).
REQ-006 Port s_axis_tvalid, input, 1: input byte valid.
REQ-007 Port s_axis_tready, output, 1: input byte accepted.
REQ-008 Port m_axis_tdata, output, 8: decoded payload byte.
REQ-009 Port m_axis_tvalid, output, 1: output byte valid.
REQ-010 Port m_axis_tready, input, 1: downstream ready.
REQ-011 Port m_axis_tlast, output, 1: last byte of a decoded frame.
REQ-012 Port m_axis_tuser, output, 1: frame-error flag, meaningful only with tlast.
REQ-013 Port frame_error, output, 1: one-cycle pulse on each errored frame.
REQ-014 Port error_count, output, ERR_CNT_WIDTH: saturating count of errored frames.

Function
REQ-015 Framing SHALL use the 0x00 delimiter only; input tlast/tkeep SHALL NOT exist or be used.
REQ-016 An input beat SHALL transfer when s_axis_tvalid && s_axis_tready.
REQ-017 s_axis_tready SHALL equal !out_valid || m_axis_tready, combinationally; no other stall source.
REQ-018 The output SHALL be one registered slot (data/valid/last/user) held stable while valid && !tready.
REQ-019 The module SHALL have an internal hold register (hold_data, hold_valid) that delays each decoded byte by one decoded byte so tlast can be applied.
REQ-020 "Produce X" SHALL mean: if hold_valid, move hold to the output slot with last=0, user=0; then hold_data<=X and hold_valid<=1.
REQ-021 "End frame(err)" SHALL mean: if hold_valid, move hold to the output slot with last=1, user=err; hold_valid<=0; pending_zero<=0; state<=CODE.
REQ-022 On an empty frame (!hold_valid), End frame SHALL drop it with no output beat; err still counts.
REQ-023 The FSM SHALL have states CODE (expecting a code byte) and DATA (cnt data bytes remaining; cnt is 8 bits).
REQ-024 In CODE, byte 0x00 SHALL trigger End frame(0).
REQ-025 In CODE, a byte b!=0x00 SHALL first Produce 0x00 if pending_zero is set.
REQ-026 In CODE, for b!=0x00, cnt<=b-1 and pending_zero<=(b!=0xFF).
REQ-027 In CODE, for b!=0x00, state<=DATA if b>1, else stay in CODE.
REQ-028 In DATA, byte 0x00 SHALL trigger End frame(1) (truncated block).
REQ-029 In DATA, byte b!=0x00 SHALL Produce b and set cnt<=cnt-1; at cnt==1 state<=CODE.
REQ-030 The implied trailing zero of the last block SHALL never be emitted, because the delimiter clears pending_zero.
REQ-031 Each accepted input byte SHALL produce at most one output byte; sustained throughput is 1 byte/cycle with m_axis_tready=1.
REQ-032 Latency SHALL be one decoded byte plus one cycle: a byte appears on m_axis one cycle after the next decoded byte or the delimiter is accepted.
REQ-033 frame_error SHALL pulse on the cycle after any End frame(1), whether or not the frame was empty.
REQ-034 On each End frame(1), error_count SHALL increment and saturate at all-ones.
REQ-035 A code byte of 0x00 cannot occur; any 0x00 SHALL always be treated as a delimiter.

Reset
REQ-036 While reset is low, all of the following SHALL be 0: m_axis_tvalid, tdata, tlast, tuser, frame_error, error_count, hold_valid, hold_data, cnt, pending_zero.
REQ-037 While reset is low, state SHALL be CODE.
REQ-038 While reset is low, s_axis_tready SHALL be 1, since the output slot is empty.
REQ-039 On reset mid-frame, the partial frame SHALL be discarded with no output beat and no error count.
REQ-040 Decoding SHALL resume at a code byte on the first cycle after deassertion.

Verification
REQ-041 Input 03 11 22 02 33 00 -> output 11 22 00 33; tlast only on 33; tuser=0; error_count=0.
REQ-042 Input 01 01 00 -> single output 00 with tlast=1, tuser=0.
REQ-043 Input FF 01..FE 00 -> 254 bytes 01..FE; no inserted zero; tlast on FE.
REQ-044 Input 04 AA BB 00 -> AA, then BB with tlast=1, tuser=1; frame_error one pulse; error_count=1.
REQ-045 Input 00 00 02 55 00 with m_axis_tready toggling 1/0 every cycle -> only 55 with tlast emitted; data stable during stalls; no loss or duplication.
REQ-046 Apply reset low after 03 11, then 02 77 00 -> only 77 with tlast; error_count=0.
